// File: rtl/nand_pkg.sv
// Shared types and opcodes for the NAND command/address sequencer.
package nand_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_DONE
    } nand_state_e;

    localparam logic [7:0] CMD_READ_1  = 8'h00;
    localparam logic [7:0] CMD_READ_2  = 8'h30;
    localparam logic [7:0] CMD_PROG_1  = 8'h80;
    localparam logic [7:0] CMD_PROG_2  = 8'h10;
    localparam logic [7:0] CMD_ERASE_1 = 8'h60;
    localparam logic [7:0] CMD_ERASE_2 = 8'hD0;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // True for states that drive a bus cycle onto the NAND pins.
    function automatic logic is_bus_state(input nand_state_e s);
        return (s == S_CMD1) || (s == S_ADDR) || (s == S_CMD2);
    endfunction

endpackage

// File: rtl/nand_we_timer.sv
// Bus-cycle phase counter: we_n low for T_WP clocks, high for T_WH clocks,
// cycle_end high during the last clock of each bus cycle.
module nand_we_timer #(
    parameter int unsigned T_WP = 2,
    parameter int unsigned T_WH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic we_n,
    output logic cycle_end
);

    localparam int unsigned TOT = T_WP + T_WH;
    localparam int unsigned PW  = (TOT > 1) ? $clog2(TOT) : 1;

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          r_active;
    logic          r_we_n;
    logic          r_cycle_end;

    // First clock after going active starts a fresh bus cycle at phase 0.
    always_comb begin
        w_phase_nxt = '0;
        if (r_active && (r_phase != PW'(TOT - 1))) begin
            w_phase_nxt = r_phase + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_phase     <= '0;
            r_active    <= 1'b0;
            r_we_n      <= 1'b1;
            r_cycle_end <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_active    <= 1'b1;
            r_we_n      <= (w_phase_nxt >= PW'(T_WP));
            r_cycle_end <= (w_phase_nxt == PW'(TOT - 1));
        end
    end

    assign we_n      = r_we_n;
    assign cycle_end = r_cycle_end;

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address sequencer: CMD1, up to ADDR_CYCLES address bytes
// (LSB first), optional CMD2, then a one-clock done pulse.
module nand_cmd_addr_seq
    import nand_pkg::*;
#(
    parameter  int unsigned IO_W        = 8,
    parameter  int unsigned ADDR_CYCLES = 4,
    parameter  int unsigned T_WP        = 2,
    parameter  int unsigned T_WH        = 2,
    localparam int unsigned AW          = IO_W * ADDR_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IO_W-1:0] cmd1,
    input  logic            has_cmd2,
    input  logic [IO_W-1:0] cmd2,
    input  logic [AW-1:0]   addr,
    input  logic [3:0]      naddr,
    output logic            busy,
    output logic            done,
    output logic            ce_n,
    output logic            cle,
    output logic            ale,
    output logic            we_n,
    output logic [IO_W-1:0] io_out,
    output logic            io_oe
);

    nand_state_e     r_state;
    nand_state_e     w_state_nxt;

    logic [IO_W-1:0] r_cmd1;
    logic [IO_W-1:0] r_cmd2;
    logic            r_has_cmd2;
    logic [AW-1:0]   r_addr_sh;
    logic [AW-1:0]   w_addr_sh_nxt;
    logic [3:0]      r_left;
    logic [3:0]      w_left_nxt;
    logic [3:0]      w_naddr_clamped;
    logic [IO_W-1:0] w_io_nxt;
    logic            w_accept;
    logic            w_run;
    logic            w_we_n;
    logic            w_cycle_end;

    logic            r_busy;
    logic            r_done;
    logic            r_ce_n;
    logic            r_cle;
    logic            r_ale;
    logic [IO_W-1:0] r_io_out;
    logic            r_io_oe;

    assign w_accept        = (r_state == S_IDLE) && start;
    assign w_naddr_clamped = (32'(naddr) > ADDR_CYCLES) ? 4'(ADDR_CYCLES) : naddr;
    assign w_run           = is_bus_state(w_state_nxt);

    nand_we_timer #(
        .T_WP (T_WP),
        .T_WH (T_WH)
    ) u_we_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (w_run),
        .we_n      (w_we_n),
        .cycle_end (w_cycle_end)
    );

    // Next state, address shifter and next IO byte; moves only at bus-cycle end.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_sh_nxt = r_addr_sh;
        w_left_nxt    = r_left;
        w_io_nxt      = '0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_CMD1;
                    w_addr_sh_nxt = addr;
                    w_left_nxt    = w_naddr_clamped;
                end
            end
            S_CMD1: begin
                if (w_cycle_end) begin
                    if (r_left != 4'd0) begin
                        w_state_nxt = S_ADDR;
                    end else if (r_has_cmd2) begin
                        w_state_nxt = S_CMD2;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                if (w_cycle_end) begin
                    w_addr_sh_nxt = r_addr_sh >> IO_W;
                    w_left_nxt    = r_left - 4'd1;
                    if (r_left == 4'd1) begin
                        w_state_nxt = r_has_cmd2 ? S_CMD2 : S_DONE;
                    end
                end
            end
            S_CMD2: begin
                if (w_cycle_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        unique case (w_state_nxt)
            S_CMD1:  w_io_nxt = w_accept ? cmd1 : r_cmd1;
            S_ADDR:  w_io_nxt = w_addr_sh_nxt[IO_W-1:0];
            S_CMD2:  w_io_nxt = r_cmd2;
            default: w_io_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cmd1     <= '0;
            r_cmd2     <= '0;
            r_has_cmd2 <= 1'b0;
            r_addr_sh  <= '0;
            r_left     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ce_n     <= 1'b1;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_io_out   <= '0;
            r_io_oe    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr_sh <= w_addr_sh_nxt;
            r_left    <= w_left_nxt;
            if (w_accept) begin
                r_cmd1     <= cmd1;
                r_cmd2     <= cmd2;
                r_has_cmd2 <= has_cmd2;
            end
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            r_ce_n   <= !w_run;
            r_io_oe  <= w_run;
            r_cle    <= (w_state_nxt == S_CMD1) || (w_state_nxt == S_CMD2);
            r_ale    <= (w_state_nxt == S_ADDR);
            r_io_out <= w_io_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ce_n   = r_ce_n;
    assign cle    = r_cle;
    assign ale    = r_ale;
    assign we_n   = w_we_n;
    assign io_out = r_io_out;
    assign io_oe  = r_io_oe;

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Directed bench for nand_cmd_addr_seq (T_WP=T_WH=2, ADDR_CYCLES=4).
module tb_nand_cmd_addr_seq;
    import nand_pkg::*;

    localparam int unsigned IO_W        = 8;
    localparam int unsigned ADDR_CYCLES = 4;
    localparam int unsigned AW          = IO_W * ADDR_CYCLES;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [IO_W-1:0] cmd1;
    logic            has_cmd2;
    logic [IO_W-1:0] cmd2;
    logic [AW-1:0]   addr;
    logic [3:0]      naddr;
    logic            busy;
    logic            done;
    logic            ce_n;
    logic            cle;
    logic            ale;
    logic            we_n;
    logic [IO_W-1:0] io_out;
    logic            io_oe;

    int n_assert = 0;
    int n_fail   = 0;

    int         nrise;
    logic       bad;
    logic [7:0] rb [16];
    logic       rc [16];
    logic       ra [16];

    nand_cmd_addr_seq #(
        .IO_W        (IO_W),
        .ADDR_CYCLES (ADDR_CYCLES),
        .T_WP        (2),
        .T_WH        (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cmd1     (cmd1),
        .has_cmd2 (has_cmd2),
        .cmd2     (cmd2),
        .addr     (addr),
        .naddr    (naddr),
        .busy     (busy),
        .done     (done),
        .ce_n     (ce_n),
        .cle      (cle),
        .ale      (ale),
        .we_n     (we_n),
        .io_out   (io_out),
        .io_oe    (io_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step a running sequence, logging io_out/cle/ale at each we_n rising edge.
    task automatic watch(input int cycles);
        logic prev;
        prev  = we_n;
        nrise = 0;
        bad   = 1'b0;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            if (prev === 1'b0 && we_n === 1'b1 && nrise < 16) begin
                rb[nrise] = io_out;
                rc[nrise] = cle;
                ra[nrise] = ale;
                nrise++;
            end
            prev = we_n;
            if (c < cycles && (done !== 1'b0 || busy !== 1'b1 || ce_n !== 1'b0 || io_oe !== 1'b1))
                bad = 1'b1;
        end
    endtask

    task automatic expect_rise(input string tag, input int i, input logic [7:0] b, input logic is_cmd);
        check({tag, "_byte"}, 32'(rb[i]), 32'(b));
        check({tag, "_cle"},  32'(rc[i]), 32'(is_cmd));
        check({tag, "_ale"},  32'(ra[i]), 32'(!is_cmd));
    endtask

    task automatic check_done_cycle(input string tag);
        check({tag, "_bus_ok"}, 32'(bad),   32'd0);
        check({tag, "_done"},   32'(done),  32'd1);
        check({tag, "_busy"},   32'(busy),  32'd1);
        check({tag, "_ce_n"},   32'(ce_n),  32'd1);
        check({tag, "_io_oe"},  32'(io_oe), 32'd0);
        check({tag, "_we_n"},   32'(we_n),  32'd1);
    endtask

    task automatic launch(input logic [7:0] c1, input logic [31:0] a, input logic [3:0] n,
                          input logic h2, input logic [7:0] c2);
        cmd1     = c1;
        addr     = a;
        naddr    = n;
        has_cmd2 = h2;
        cmd2     = c2;
        start    = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cmd1     = '0;
        has_cmd2 = 1'b0;
        cmd2     = '0;
        addr     = '0;
        naddr    = '0;

        // Reset held two clocks
        tick();
        tick();
        check("rst_ce_n",   32'(ce_n),   32'd1);
        check("rst_we_n",   32'(we_n),   32'd1);
        check("rst_cle",    32'(cle),    32'd0);
        check("rst_ale",    32'(ale),    32'd0);
        check("rst_io_oe",  32'(io_oe),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_io_out", 32'(io_out), 32'd0);
        reset = 1'b0;
        tick();

        // READ: 00, 4 address bytes, 30 -> done at k+24
        launch(CMD_READ_1, 32'hABAAA9A8, 4'd4, 1'b1, CMD_READ_2);
        start = 1'b0;
        check("rd_k_cle",  32'(cle),  32'd1);
        check("rd_k_we_n", 32'(we_n), 32'd0);
        check("rd_k_busy", 32'(busy), 32'd1);
        watch(24);
        check("rd_nrise", 32'(nrise), 32'd6);
        expect_rise("rd0", 0, 8'h00, 1'b1);
        expect_rise("rd1", 1, 8'hA8, 1'b0);
        expect_rise("rd2", 2, 8'hA9, 1'b0);
        expect_rise("rd3", 3, 8'hAA, 1'b0);
        expect_rise("rd4", 4, 8'hAB, 1'b0);
        expect_rise("rd5", 5, 8'h30, 1'b1);
        check_done_cycle("rd");
        tick();
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_idle_done", 32'(done), 32'd0);

        // RESET command only -> done at k+4
        launch(CMD_RESET, 32'h12345678, 4'd0, 1'b0, 8'h30);
        start = 1'b0;
        watch(4);
        check("rst_cmd_nrise", 32'(nrise), 32'd1);
        expect_rise("rst_cmd0", 0, CMD_RESET, 1'b1);
        check_done_cycle("rst_cmd");
        tick();
        check("rst_cmd_idle_done", 32'(done), 32'd0);

        // start held high; inputs changed after capture
        launch(CMD_ERASE_1, 32'h000000C3, 4'd1, 1'b0, CMD_ERASE_2);
        cmd1 = CMD_PROG_1;
        addr = 32'h0000005A;
        check("hold_k_io", 32'(io_out), 32'(CMD_ERASE_1));
        watch(8);
        check("hold_nrise", 32'(nrise), 32'd2);
        expect_rise("hold0", 0, CMD_ERASE_1, 1'b1);
        expect_rise("hold1", 1, 8'hC3, 1'b0);
        check_done_cycle("hold");
        tick();
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_ce_n", 32'(ce_n), 32'd1);
        tick();
        check("hold_2nd_busy", 32'(busy),   32'd1);
        check("hold_2nd_cle",  32'(cle),    32'd1);
        check("hold_2nd_io",   32'(io_out), 32'(CMD_PROG_1));
        start = 1'b0;
        watch(8);
        check("hold2_nrise", 32'(nrise), 32'd2);
        expect_rise("hold2_0", 0, CMD_PROG_1, 1'b1);
        expect_rise("hold2_1", 1, 8'h5A, 1'b0);
        check_done_cycle("hold2");
        tick();

        // Reset during the third address cycle
        launch(CMD_READ_1, 32'hDDCCBBAA, 4'd4, 1'b1, CMD_READ_2);
        start = 1'b0;
        repeat (13) tick();
        check("abort_pre_ale", 32'(ale),    32'd1);
        check("abort_pre_io",  32'(io_out), 32'hCC);
        reset = 1'b1;
        tick();
        check("abort_ce_n",   32'(ce_n),   32'd1);
        check("abort_we_n",   32'(we_n),   32'd1);
        check("abort_cle",    32'(cle),    32'd0);
        check("abort_ale",    32'(ale),    32'd0);
        check("abort_io_out", 32'(io_out), 32'd0);
        check("abort_io_oe",  32'(io_oe),  32'd0);
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        reset = 1'b0;
        bad   = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("abort_no_done", 32'(bad), 32'd0);
        launch(CMD_READ_1, 32'h00001122, 4'd2, 1'b1, CMD_READ_2);
        start = 1'b0;
        watch(16);
        check("post_nrise", 32'(nrise), 32'd4);
        expect_rise("post0", 0, CMD_READ_1, 1'b1);
        expect_rise("post1", 1, 8'h22, 1'b0);
        expect_rise("post2", 2, 8'h11, 1'b0);
        expect_rise("post3", 3, CMD_READ_2, 1'b1);
        check_done_cycle("post");
        tick();

        // naddr=7 clamps to 4 address cycles -> done at k+20
        launch(CMD_PROG_1, 32'h44332211, 4'd7, 1'b0, CMD_PROG_2);
        start = 1'b0;
        watch(20);
        check("clamp_nrise", 32'(nrise), 32'd5);
        expect_rise("clamp0", 0, CMD_PROG_1, 1'b1);
        expect_rise("clamp1", 1, 8'h11, 1'b0);
        expect_rise("clamp2", 2, 8'h22, 1'b0);
        expect_rise("clamp3", 3, 8'h33, 1'b0);
        expect_rise("clamp4", 4, 8'h44, 1'b0);
        check_done_cycle("clamp");
        tick();
        check("clamp_idle_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
